// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Guarded so a bad DIGIT reaches the elaboration check instead of a divide by zero.
   function automatic int calc_steps(input int width, input int digit);
      return (digit > 0) ? (width / digit) : 1;
   endfunction

   function automatic int cnt_width(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_n_adder_digit.sv
// Combinational ripple of DIGIT full-adder cells; c_msb is the carry into the top cell.
module adder_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   always_comb begin
      logic cc;
      cc    = ci;
      c_msb = ci;
      s     = '0;
      for (int i = 0; i < DIGIT; i++) begin
         c_msb = cc;
         s[i]  = x[i] ^ y[i] ^ cc;
         cc    = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
      end
      co = cc;
   end

endmodule

// File: rtl/serial_adder_n.sv
// Digit-serial WIDTH-bit adder/subtractor: DIGIT bits per cycle, carry held between steps,
// start/done handshake. start is taken only while busy=0; done is a one-cycle result pulse.
module serial_adder_n
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int STEPS = calc_steps(WIDTH, DIGIT);
   localparam int CW    = cnt_width(STEPS);

   if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder_n: WIDTH must be >= 2 and DIGIT must divide WIDTH");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] psum_q, psum_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [DIGIT-1:0] dig_s;
   logic             dig_co;
   logic             dig_cmsb;

   adder_digit #(.DIGIT(DIGIT)) u_digit (
      .x     (a_q[DIGIT-1:0]),
      .y     (b_q[DIGIT-1:0]),
      .ci    (carry_q),
      .s     (dig_s),
      .co    (dig_co),
      .c_msb (dig_cmsb)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      psum_d  = psum_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = dig_co;
            // New digit enters at the top; after STEPS shifts the word is in place.
            psum_d  = (psum_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(STEPS - 1)) begin
               sum_d   = psum_d;
               cout_d  = dig_co;
               ovf_d   = dig_cmsb ^ dig_co;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         psum_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         psum_q  <= psum_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, carry held in a flop between steps.
- Successor to the single-bit full adder: same ripple-carry arithmetic, generalised in width, with an add/subtract mode, signed-overflow flag and a start/done handshake.
- Used wherever an N-bit add is acceptable over several cycles in exchange for small area.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH. Elaboration error otherwise.
- STEPS (localparam), WIDTH/DIGIT, cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- sub  input  1  0: a+b+cin; 1: a+~b+1 (cin ignored); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cin  input  1  carry-in for add mode; sampled with start
- busy  output  1  high while digits are being processed
- done  output  1  one-cycle pulse; results valid
- sum  output  WIDTH  result
- cout  output  1  carry out of the MSB (in subtract mode, 1 means no borrow)
- overflow  output  1  two's-complement overflow (carry into MSB xor carry out)

Behaviour:
- Reset (rst_n low, asynchronous) forces the following:
  - state=IDLE
  - busy=0, done=0
  - sum=0, cout=0, overflow=0
  - internal operand, carry and count registers cleared
- States: IDLE, RUN, DONE.
- Start acceptance (IDLE or DONE, i.e. busy=0):
  - If start=1, latch a, (sub ? ~b : b), and carry = (sub ? 1 : cin).
  - Step count = 0; go to RUN.
  - If start=0, IDLE stays IDLE and DONE returns to IDLE.
- RUN, each edge:
  - Add the DIGIT LSBs of both operand shift registers plus the carry flop.
  - Shift the operands right by DIGIT.
  - Write the digit sum into the top DIGIT bits of the partial-sum shift register, shifting it right.
  - Carry flop takes the digit carry-out; count increments.
- RUN, edge with count = STEPS-1:
  - Additionally load sum = the completed partial word, cout = digit carry-out, overflow = carry into bit WIDTH-1 xor carry out.
  - Go to DONE.
- DONE: done=1 for exactly one cycle; busy=0.
- Latency: if the start-sampling edge is E0, done is high in the cycle after edge E(STEPS), i.e. STEPS cycles after start.
- busy=1 exactly in RUN (STEPS cycles). start, sub, a, b and cin are ignored while busy=1; no queueing.
- Back-to-back operation:
  - start=1 in the DONE cycle is accepted.
  - The next done follows STEPS cycles later.
  - Throughput is one result per STEPS+1 cycles.
- sum, cout and overflow hold their last value until the final-step edge of the next operation; they never show partial results.
- Width rules:
  - Result is modulo 2^WIDTH.
  - cout is the (WIDTH+1)th bit.
  - Subtract result equals (a - b) mod 2^WIDTH.
- Reset asserted mid-RUN aborts the operation with no done pulse; all outputs take reset values. The first start after reset release behaves normally.
- DIGIT=WIDTH is legal: STEPS=1, busy high for 1 cycle, done on the next cycle.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - a function computing STEPS
  - the count width, $clog2(STEPS) with a minimum of 1
- One sub-module, adder_digit, parametrised by DIGIT:
  - Combinational ripple of DIGIT full-adder cells.
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: s[DIGIT], co, c_msb (carry into the top cell, used for overflow).
- Top level instantiates one adder_digit and holds the FSM and shift registers.

Test Plan:
- Carry out, WIDTH=8, DIGIT=1, sub=0: a=0xFF, b=0x01, cin=0 -> done exactly 8 cycles after start; sum=0x00, cout=1, overflow=0.
- Signed overflow: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1.
- Subtract: sub=1, a=0x05, b=0x07, cin=1 (must be ignored) -> sum=0xFE, cout=0, overflow=0.
- Exhaustive, WIDTH=4, DIGIT=2: all 512 combinations of a, b, cin in add mode -> {cout,sum} == a+b+cin, busy high 2 cycles, done 1 cycle.
- Protocol:
  - start pulsed in cycle 3 of RUN with different operands -> ignored, result matches the first operands.
  - start held high in the DONE cycle -> second operation accepted, done 9 cycles after the first done.
  - sum stays at the old value until the final step.
- Reset mid-operation: rst_n low asynchronously (between edges) during RUN step 3 -> busy=0, done=0, sum=0 immediately with no done pulse. After release, a=0x10, b=0x20 -> sum=0x30.
